// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder that streams encoded words into a single-port instruction memory.
// Optional IMM_RANGE_CHECK_EN rejects immediates that do not fit their format instead of truncating.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [2:0]        i_type,
  input  logic [6:0]        i_opcode,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [2:0]        i_f3,
  input  logic [6:0]        i_f7,
  input  logic [31:0]       i_imm,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_err
);

  localparam logic [ADDR_W:0] DepthC = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWrite, StFull} state_e;

  state_e          r_state;
  logic [31:0]     r_word;
  logic [ADDR_W:0] r_count;
  logic            r_err;

  logic [31:0]     w_word;
  logic            w_legal;
  logic            w_fits;
  logic            w_ok;
  logic [ADDR_W:0] w_count_nxt;

  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (i_type)
      3'd0: w_word = {i_f7, i_rs2, i_rs1, i_f3, i_rd, i_opcode};
      3'd1: w_word = {i_imm[11:0], i_rs1, i_f3, i_rd, i_opcode};
      3'd2: w_word = {i_imm[11:5], i_rs2, i_rs1, i_f3, i_imm[4:0], i_opcode};
      3'd3: w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_f3, i_imm[4:1], i_imm[11],
                      i_opcode};
      3'd4: w_word = {i_imm[31:12], i_rd, i_opcode};
      3'd5: w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
      default: w_legal = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Sign-extension bits above the field must all equal the field's sign bit.
  always_comb begin
    w_fits = 1'b1;
    case (i_type)
      3'd1, 3'd2: w_fits = (&i_imm[31:11]) | ~(|i_imm[31:11]);
      3'd3:       w_fits = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];
      3'd4:       w_fits = ~(|i_imm[11:0]);
      3'd5:       w_fits = ((&i_imm[31:20]) | ~(|i_imm[31:20])) & ~i_imm[0];
      default:    w_fits = 1'b1;
    endcase
  end
`else
  logic w_unused_imm0;
  assign w_unused_imm0 = i_imm[0];
  assign w_fits        = 1'b1;
`endif

  assign w_ok        = w_legal & w_fits;
  assign w_count_nxt = r_count + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_word  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (i_clear) begin
        r_state <= StIdle;
        r_count <= '0;
      end else begin
        case (r_state)
          StIdle: begin
            if (i_valid) begin
              if (w_ok) begin
                r_word  <= w_word;
                r_state <= StWrite;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          StWrite: begin
            r_count <= w_count_nxt;
            r_state <= (w_count_nxt == DepthC) ? StFull : StIdle;
          end
          StFull:  r_state <= StFull;
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Reset and clear are sampled at the edge, so gate the strobes here to kill the current cycle.
  assign o_ready      = (r_state == StIdle) & i_rst_n;
  assign o_imem_we    = (r_state == StWrite) & i_rst_n & ~i_clear;
  assign o_imem_addr  = r_count[ADDR_W-1:0];
  assign o_imem_wdata = r_word;
  assign o_count      = r_count;
  assign o_full       = (r_state == StFull);
  assign o_err        = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader (DEPTH=4); follows IMM_RANGE_CHECK_EN.
module tb_instr_encoder_loader;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n, clear, valid, ready;
  logic [2:0]        typ;
  logic [6:0]        opcode, f7;
  logic [4:0]        rd, rs1, rs2;
  logic [2:0]        f3;
  logic [31:0]       imm;
  logic              we, full, err;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [ADDR_W:0]   count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid), .o_ready(ready),
    .i_type(typ), .i_opcode(opcode), .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_f3(f3),
    .i_f7(f7), .i_imm(imm), .o_imem_we(we), .o_imem_addr(addr), .o_imem_wdata(wdata),
    .o_count(count), .o_full(full), .o_err(err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] fn3,
                       input logic [6:0] fn7, input logic [31:0] im);
    typ = t; opcode = op; rd = d; rs1 = s1; rs2 = s2; f3 = fn3; f7 = fn7; imm = im;
    valid = 1'b1;
  endtask

  // One accepted word: checks the write cycle and the count after it.
  task automatic send(input string tag, input logic [31:0] exp_word, input int exp_addr);
    step();
    valid = 1'b0;
    check({tag, "_we"}, 32'(we), 32'd1);
    check({tag, "_addr"}, 32'(addr), 32'(exp_addr));
    check({tag, "_wdata"}, wdata, exp_word);
    check({tag, "_ready_wr"}, 32'(ready), 32'd0);
    step();
    check({tag, "_count"}, 32'(count), 32'(exp_addr + 1));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; valid = 1'b0;
    drive(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    valid = 1'b0;
    step();
    step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 32'(ready), 32'd1);

    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    send("add", 32'h002081B3, 0);
    drive(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    send("addi", 32'hFFF00293, 1);
    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send("sw", 32'h0020A423, 2);
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    send("beq", 32'hFE208EE3, 3);
    check("full_flag", 32'(full), 32'd1);
    check("full_ready", 32'(ready), 32'd0);

    valid = 1'b1;
    step();
    check("full_no_we", 32'(we), 32'd0);
    check("full_count", 32'(count), 32'd4);
    valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_full", 32'(full), 32'd0);
    check("clr_ready", 32'(ready), 32'd1);

    // Valid held high: ready alternates and words land at consecutive addresses.
    drive(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    check("b2b_rdy0", 32'(ready), 32'd1);
    step();
    check("b2b_rdy1", 32'(ready), 32'd0);
    check("b2b_addr0", 32'(addr), 32'd0);
    check("lui_wdata", wdata, 32'h123453B7);
    step();
    check("b2b_rdy2", 32'(ready), 32'd1);
    step();
    check("b2b_rdy3", 32'(ready), 32'd0);
    check("b2b_we1", 32'(we), 32'd1);
    check("b2b_addr1", 32'(addr), 32'd1);
    valid = 1'b0;
    step();
    check("b2b_count", 32'(count), 32'd2);

    drive(3'd7, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    step();
    valid = 1'b0;
    check("ill_err", 32'(err), 32'd1);
    check("ill_we", 32'(we), 32'd0);
    check("ill_count", 32'(count), 32'd2);
    check("ill_ready", 32'(ready), 32'd1);
    step();
    check("ill_err_drop", 32'(err), 32'd0);

    drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    step();
    valid = 1'b0;
    clear = 1'b1;
    #1;
    check("clrwr_we", 32'(we), 32'd0);
    step();
    clear = 1'b0;
    check("clrwr_count", 32'(count), 32'd0);
    check("clrwr_ready", 32'(ready), 32'd1);

    drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    send("jal", 32'h008000EF, 0);

`ifdef IMM_RANGE_CHECK_EN
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
    step();
    valid = 1'b0;
    check("b4096_err", 32'(err), 32'd1);
    check("b4096_we", 32'(we), 32'd0);
    step();
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    step();
    valid = 1'b0;
    check("b3_err", 32'(err), 32'd1);
    check("b3_we", 32'(we), 32'd0);
    step();
    check("brej_count", 32'(count), 32'd1);
`else
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
    send("b4096", 32'h80208063, 1);
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send("b3", 32'h00208163, 2);
`endif

    // Reset in the middle of a write cycle.
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    step();
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstwr_we", 32'(we), 32'd0);
    check("rstwr_ready", 32'(ready), 32'd0);
    step();
    check("rstwr_count", 32'(count), 32'd0);
    check("rstwr_wdata", wdata, 32'd0);
    check("rstwr_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rstwr_idle", 32'(ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
